// File: rtl/inst_buffer.sv
// Dual-slot instruction buffer between fetch and decode.
// Circular FIFO; occupancy comes from wrap-bit pointers.
module inst_buffer #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic             flush_i,
  input  logic [1:0]       fetch_valid_i,
  input  logic [1:0][31:0] fetch_pc_i,
  input  logic [1:0][31:0] fetch_inst_i,
  input  logic [1:0]       fetch_excp_i,
  output logic             fetch_ready_o,
  output logic [1:0]       dec_valid_o,
  output logic [1:0][31:0] dec_pc_o,
  output logic [1:0][31:0] dec_inst_o,
  output logic [1:0]       dec_excp_o,
  input  logic [1:0]       dec_ready_i,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] RDY_MAX = (AW+1)'(DEPTH - 2);

  logic [AW:0]   head_q, head_d;
  logic [AW:0]   tail_q, tail_d;
  logic [AW:0]   used;
  logic [AW-1:0] hidx0, hidx1;
  logic [AW-1:0] tidx0, tidx1;
  logic [1:0]    push_n, pop_n;
  logic          vld0, vld1;

  logic [31:0] pc_q   [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic        excp_q [DEPTH];

  // Wrap bit makes tail-head the exact occupancy, 0..DEPTH
  assign used    = tail_q - head_q;
  assign count_o = CW'(used);

  assign fetch_ready_o = (used <= RDY_MAX);

  assign vld0 = (used != '0) & ~flush_i;
  assign vld1 = (used >= (AW+1)'(2)) & ~flush_i;
  assign dec_valid_o = {vld1, vld0};

  assign hidx0 = head_q[AW-1:0];
  assign hidx1 = hidx0 + AW'(1);
  assign tidx0 = tail_q[AW-1:0];
  assign tidx1 = tidx0 + AW'(1);

  always_comb begin
    push_n = 2'd0;
    if (fetch_ready_o && fetch_valid_i[0])
      push_n = fetch_valid_i[1] ? 2'd2 : 2'd1;
  end

  // Slot 1 only pops together with slot 0
  always_comb begin
    pop_n = 2'd0;
    if (vld0 && dec_ready_i[0])
      pop_n = (vld1 && dec_ready_i[1]) ? 2'd2 : 2'd1;
  end

  always_comb begin
    head_d = head_q + (AW+1)'(pop_n);
    tail_d = tail_q + (AW+1)'(push_n);
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage carries no reset
  always_ff @(posedge clk) begin
    if (!flush_i && push_n != 2'd0) begin
      pc_q[tidx0]   <= fetch_pc_i[0];
      inst_q[tidx0] <= fetch_inst_i[0];
      excp_q[tidx0] <= fetch_excp_i[0];
      if (push_n == 2'd2) begin
        pc_q[tidx1]   <= fetch_pc_i[1];
        inst_q[tidx1] <= fetch_inst_i[1];
        excp_q[tidx1] <= fetch_excp_i[1];
      end
    end
  end

  always_comb begin
    dec_pc_o   = '0;
    dec_inst_o = '0;
    dec_excp_o = '0;
    if (vld0) begin
      dec_pc_o[0]   = pc_q[hidx0];
      dec_inst_o[0] = inst_q[hidx0];
      dec_excp_o[0] = excp_q[hidx0];
    end
    if (vld1) begin
      dec_pc_o[1]   = pc_q[hidx1];
      dec_inst_o[1] = inst_q[hidx1];
      dec_excp_o[1] = excp_q[hidx1];
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer.
// Inputs change 1ns after posedge; outputs checked mid-cycle.
module tb_inst_buffer;

  logic             clk;
  logic             a_rst_n;
  logic             flush_i;
  logic [1:0]       fetch_valid_i;
  logic [1:0][31:0] fetch_pc_i;
  logic [1:0][31:0] fetch_inst_i;
  logic [1:0]       fetch_excp_i;
  logic             fetch_ready_o;
  logic [1:0]       dec_valid_o;
  logic [1:0][31:0] dec_pc_o;
  logic [1:0][31:0] dec_inst_o;
  logic [1:0]       dec_excp_o;
  logic [1:0]       dec_ready_i;
  logic [4:0]       count_o;

  int checks = 0;
  int errors = 0;

  inst_buffer #(.DEPTH(16)) dut (
    .clk(clk),
    .a_rst_n(a_rst_n),
    .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i),
    .fetch_pc_i(fetch_pc_i),
    .fetch_inst_i(fetch_inst_i),
    .fetch_excp_i(fetch_excp_i),
    .fetch_ready_o(fetch_ready_o),
    .dec_valid_o(dec_valid_o),
    .dec_pc_o(dec_pc_o),
    .dec_inst_o(dec_inst_o),
    .dec_excp_o(dec_excp_o),
    .dec_ready_i(dec_ready_i),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0013;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i       = 1'b0;
    fetch_valid_i = 2'b00;
    fetch_excp_i  = 2'b00;
    dec_ready_i   = 2'b00;
  endtask

  task automatic drive_pair(input logic [31:0] pc, input logic [1:0] v);
    fetch_valid_i   = v;
    fetch_pc_i[0]   = pc;
    fetch_pc_i[1]   = pc + 32'd4;
    fetch_inst_i[0] = inst_of(pc);
    fetch_inst_i[1] = inst_of(pc + 32'd4);
  endtask

  task automatic do_reset();
    idle();
    a_rst_n = 1'b0;
    step();
    step();
    a_rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    a_rst_n = 1'b0;
    #3;
    checks++;
    if (count_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", count_o);
    end
    checks++;
    if (dec_valid_o !== 2'b00 || dec_pc_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_out: valid %b pc %h expected 00 / 0", dec_valid_o, dec_pc_o);
    end
    checks++;
    if (fetch_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", fetch_ready_o);
    end
    step();
    a_rst_n = 1'b1;
    #1;
  endtask

  task automatic test_push_basic();
    do_reset();
    drive_pair(32'h1c00_0000, 2'b11);
    #1;
    checks++;
    if (dec_valid_o !== 2'b00) begin
      errors++;
      $display("FAIL no_bypass: valid %b expected 00", dec_valid_o);
    end
    step();
    idle();
    #1;
    checks++;
    if (count_o !== 5'd2 || dec_valid_o !== 2'b11) begin
      errors++;
      $display("FAIL push_basic_cnt: count %0d valid %b expected 2 / 11", count_o, dec_valid_o);
    end
    checks++;
    if (dec_pc_o[0] !== 32'h1c00_0000 || dec_pc_o[1] !== 32'h1c00_0004) begin
      errors++;
      $display("FAIL push_basic_pc: got %h %h expected 1c000000 1c000004", dec_pc_o[0], dec_pc_o[1]);
    end
    checks++;
    if (dec_inst_o[1] !== inst_of(32'h1c00_0004)) begin
      errors++;
      $display("FAIL push_basic_inst: got %h expected %h", dec_inst_o[1], inst_of(32'h1c00_0004));
    end
  endtask

  task automatic test_fill();
    logic [31:0] pc;
    do_reset();
    pc = 32'h1c00_0000;
    for (int i = 0; i < 7; i++) begin
      drive_pair(pc, 2'b11);
      step();
      pc = pc + 32'd8;
    end
    drive_pair(pc, 2'b01);
    step();
    idle();
    #1;
    checks++;
    if (count_o !== 5'd15 || fetch_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_15: count %0d ready %b expected 15 / 0", count_o, fetch_ready_o);
    end
    drive_pair(32'h7777_0000, 2'b11);
    step();
    idle();
    #1;
    checks++;
    if (count_o !== 5'd15) begin
      errors++;
      $display("FAIL fill_reject: count %0d expected 15", count_o);
    end
    dec_ready_i = 2'b01;
    step();
    idle();
    #1;
    checks++;
    if (fetch_ready_o !== 1'b1 || count_o !== 5'd14) begin
      errors++;
      $display("FAIL fill_pop1: ready %b count %0d expected 1 / 14", fetch_ready_o, count_o);
    end
    checks++;
    if (dec_pc_o[0] !== 32'h1c00_0004) begin
      errors++;
      $display("FAIL fill_head: pc %h expected 1c000004", dec_pc_o[0]);
    end
  endtask

  task automatic test_steady();
    logic [31:0] nxt;
    logic [31:0] exp;
    do_reset();
    nxt = 32'h0000_1000;
    exp = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      drive_pair(nxt, 2'b11);
      step();
      nxt = nxt + 32'd8;
    end
    for (int i = 0; i < 20; i++) begin
      drive_pair(nxt, 2'b11);
      dec_ready_i = 2'b11;
      #1;
      checks++;
      if (dec_valid_o !== 2'b11 || dec_pc_o[0] !== exp || dec_pc_o[1] !== exp + 32'd4
          || dec_inst_o[0] !== inst_of(exp) || count_o !== 5'd8) begin
        errors++;
        $display("FAIL steady_%0d: valid %b pc %h %h cnt %0d expected 11 %h %h 8",
                 i, dec_valid_o, dec_pc_o[0], dec_pc_o[1], count_o, exp, exp + 32'd4);
      end
      step();
      nxt = nxt + 32'd8;
      exp = exp + 32'd8;
    end
    idle();
    #1;
    checks++;
    if (count_o !== 5'd8 || dec_pc_o[0] !== exp) begin
      errors++;
      $display("FAIL steady_end: count %0d pc %h expected 8 %h", count_o, dec_pc_o[0], exp);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive_pair(32'h2000, 2'b11);
    step();
    drive_pair(32'h2008, 2'b01);
    step();
    idle();
    dec_ready_i = 2'b10;
    step();
    idle();
    #1;
    checks++;
    if (count_o !== 5'd3 || dec_pc_o[0] !== 32'h2000) begin
      errors++;
      $display("FAIL illegal_ready: count %0d pc %h expected 3 2000", count_o, dec_pc_o[0]);
    end
    drive_pair(32'h3000, 2'b10);
    step();
    idle();
    #1;
    checks++;
    if (count_o !== 5'd3) begin
      errors++;
      $display("FAIL illegal_valid: count %0d expected 3", count_o);
    end
    dec_ready_i = 2'b11;
    step();
    idle();
    #1;
    checks++;
    if (count_o !== 5'd1 || dec_valid_o !== 2'b01 || dec_pc_o[0] !== 32'h2008 || dec_pc_o[1] !== 32'd0) begin
      errors++;
      $display("FAIL single_slot: cnt %0d valid %b pc %h %h expected 1 01 2008 0",
               count_o, dec_valid_o, dec_pc_o[0], dec_pc_o[1]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_pair(32'h4000 + 32'(i * 8), 2'b11);
      step();
    end
    drive_pair(32'h4800, 2'b11);
    dec_ready_i = 2'b11;
    flush_i = 1'b1;
    #1;
    checks++;
    if (dec_valid_o !== 2'b00 || dec_pc_o !== 64'd0) begin
      errors++;
      $display("FAIL flush_cycle: valid %b pc %h expected 00 / 0", dec_valid_o, dec_pc_o);
    end
    step();
    idle();
    #1;
    checks++;
    if (count_o !== 5'd0 || dec_valid_o !== 2'b00 || fetch_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_next: cnt %0d valid %b ready %b expected 0 00 1",
               count_o, dec_valid_o, fetch_ready_o);
    end
    drive_pair(32'h5000, 2'b11);
    step();
    idle();
    #1;
    checks++;
    if (count_o !== 5'd2 || dec_pc_o[0] !== 32'h5000) begin
      errors++;
      $display("FAIL flush_resume: cnt %0d pc %h expected 2 5000", count_o, dec_pc_o[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_pair(32'h6000, 2'b11);
    step();
    drive_pair(32'h6008, 2'b11);
    step();
    drive_pair(32'h6010, 2'b01);
    step();
    idle();
    #1;
    checks++;
    if (count_o !== 5'd5) begin
      errors++;
      $display("FAIL pre_async: count %0d expected 5", count_o);
    end
    a_rst_n = 1'b0;
    #1;
    checks++;
    if (count_o !== 5'd0 || dec_valid_o !== 2'b00 || dec_pc_o !== 64'd0
        || dec_inst_o !== 64'd0 || dec_excp_o !== 2'b00 || fetch_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: cnt %0d valid %b pc %h ready %b expected 0 00 0 1",
               count_o, dec_valid_o, dec_pc_o, fetch_ready_o);
    end
    step();
    a_rst_n = 1'b1;
    drive_pair(32'h7000, 2'b11);
    fetch_excp_i = 2'b10;
    step();
    idle();
    #1;
    checks++;
    if (count_o !== 5'd2 || dec_pc_o[0] !== 32'h7000 || dec_excp_o !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_push: cnt %0d pc %h excp %b expected 2 7000 10",
               count_o, dec_pc_o[0], dec_excp_o);
    end
  endtask

  initial begin
    fetch_pc_i   = '0;
    fetch_inst_i = '0;
    idle();
    a_rst_n = 1'b0;
    test_reset();
    test_push_basic();
    test_fill();
    test_steady();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
